seg_frame_loader: RTL and testbench

Host-side controller that drives the serial load port (shift clock, data, latch) of the 7-segment clock display shifter. It takes four BCD digits plus per-digit blank flags, encodes them to segment patterns and packs them into a 32-bit frame. It then serializes the frame MSB-first and pulses latch so the display refresh logic picks up the new frame. It sits between the timekeeping logic and the display shifter. A one-deep pending buffer lets the timekeeper post updates at any time without handshaking.

---
 rtl/seg_frame_loader.sv | 144 ++++++++++++++
 tb/tb_seg_frame_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_loader.sv
// Serial loader for the 7-segment display shifter: encodes four BCD digits into a
// 32-bit frame, shifts it out MSB-first on sclk/sdata, then pulses slatch.
module seg_frame_loader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [15:0] bcd,
  input  logic [3:0]  blank,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic        busy,
  output logic        pending
);

  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, LAT_HI, LAT_GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  function automatic logic [6:0] seg_encode(input logic [3:0] d, input logic b);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return b ? 7'h00 : s;
  endfunction

  function automatic logic [31:0] frame_encode(input logic [15:0] d, input logic [3:0] b);
    return {1'b0, seg_encode(d[15:12], b[3]), 1'b0, seg_encode(d[11:8], b[2]),
            1'b0, seg_encode(d[7:4],   b[1]), 1'b0, seg_encode(d[3:0],  b[0])};
  endfunction

  state_t      state, state_nx;
  logic [7:0]  div, div_nx;
  logic [4:0]  bit_cnt, bit_nx;
  logic [31:0] shift, shift_nx;
  logic [31:0] pend_frame, pend_nx;
  logic        pending_nx;
  logic        div_end;
  logic [31:0] frame_in;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx   = state;
    div_nx     = div;
    bit_nx     = bit_cnt;
    shift_nx   = shift;
    pend_nx    = pend_frame;
    pending_nx = pending;
    frame_in   = frame_encode(bcd, blank);
    div_end    = (div == DIV_LAST);

    if (state != IDLE) div_nx = div_end ? 8'd0 : div + 8'd1;

    case (state)
      IDLE: begin
        if (frame_valid) begin
          shift_nx = frame_in;
          bit_nx   = 5'd0;
          div_nx   = 8'd0;
          state_nx = BIT_LO;
        end
      end
      BIT_LO: if (div_end) state_nx = BIT_HI;
      BIT_HI: begin
        if (div_end) begin
          if (bit_cnt == 5'd31) begin
            state_nx = LAT_HI;
          end else begin
            shift_nx = {shift[30:0], 1'b0};
            bit_nx   = bit_cnt + 5'd1;
            state_nx = BIT_LO;
          end
        end
      end
      LAT_HI: if (div_end) state_nx = LAT_GAP;
      LAT_GAP: begin
        if (div_end) begin
          bit_nx     = 5'd0;
          pending_nx = 1'b0;
          // A strobe landing on the final gap cycle supersedes any buffered frame.
          if (frame_valid) begin
            shift_nx = frame_in;
            state_nx = BIT_LO;
          end else if (pending) begin
            shift_nx = pend_frame;
            state_nx = BIT_LO;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (frame_valid && state != IDLE && !(state == LAT_GAP && div_end)) begin
      pend_nx    = frame_in;
      pending_nx = 1'b1;
    end
  end

  // Outputs are decoded from next-state values so they are registered yet aligned
  // with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= 8'd0;
      bit_cnt    <= 5'd0;
      shift      <= 32'd0;
      pend_frame <= 32'd0;
      pending    <= 1'b0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      slatch     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      bit_cnt    <= bit_nx;
      shift      <= shift_nx;
      pend_frame <= pend_nx;
      pending    <= pending_nx;
      sclk       <= (state_nx == BIT_HI);
      sdata      <= (state_nx == BIT_LO || state_nx == BIT_HI) && shift_nx[31];
      slatch     <= (state_nx == LAT_HI);
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_seg_frame_loader.sv
// Directed bench for seg_frame_loader: one instance at CLK_DIV=4, one at CLK_DIV=1,
// with a serial-port monitor that reassembles latched frames.
module tb_seg_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  fv = 2'b00;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  blank = 4'h0;
  logic [1:0]  sclk_v, sdata_v, slatch_v, busy_v, pending_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_frame_loader #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv[0]), .bcd(bcd), .blank(blank),
    .sclk(sclk_v[0]), .sdata(sdata_v[0]), .slatch(slatch_v[0]),
    .busy(busy_v[0]), .pending(pending_v[0]));

  seg_frame_loader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv[1]), .bcd(bcd), .blank(blank),
    .sclk(sclk_v[1]), .sdata(sdata_v[1]), .slatch(slatch_v[1]),
    .busy(busy_v[1]), .pending(pending_v[1]));

  // Monitor state per instance: captured bits, latched frames, latch stats.
  logic [31:0] cap [2];
  int          nbits [2];
  logic [1:0]  p_sclk = '0, p_slatch = '0, p_sdata = '0;
  int          stab [2];
  int          lat_cyc [2];
  int          lat_pulse [2];
  logic [31:0] frames [2][$];
  int          bits [2][$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0; nbits[k] = 0; stab[k] = 0; lat_cyc[k] = 0; lat_pulse[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        nbits[k]    <= 0;
        p_sclk[k]   <= 1'b0;
        p_slatch[k] <= 1'b0;
        p_sdata[k]  <= 1'b0;
      end else begin
        p_sclk[k]   <= sclk_v[k];
        p_slatch[k] <= slatch_v[k];
        p_sdata[k]  <= sdata_v[k];
        if (sclk_v[k] && !p_sclk[k]) begin
          cap[k]   <= {cap[k][30:0], sdata_v[k]};
          nbits[k] <= nbits[k] + 1;
          if (sdata_v[k] !== p_sdata[k]) stab[k] <= stab[k] + 1;
        end
        if (slatch_v[k]) lat_cyc[k] <= lat_cyc[k] + 1;
        if (slatch_v[k] && !p_slatch[k]) begin
          frames[k].push_back(cap[k]);
          bits[k].push_back(nbits[k]);
          nbits[k]     <= 0;
          lat_pulse[k] <= lat_pulse[k] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic strobe(input int k, input logic [15:0] b, input logic [3:0] bl);
    @(negedge clk);
    bcd   = b;
    blank = bl;
    fv[k] = 1'b1;
    @(negedge clk);
    fv[k] = 1'b0;
  endtask

  // Counts negedges (continuing from start) until busy drops; records the first
  // count at which pending was seen low.
  task automatic wait_idle(input int k, input string tag, input int start,
                           output int cyc, output int pend_drop);
    cyc = start;
    pend_drop = -1;
    while (busy_v[k] && cyc < start + 2000) begin
      @(negedge clk);
      cyc++;
      if (!pending_v[k] && pend_drop < 0) pend_drop = cyc;
    end
    check({tag, "_timeout"}, busy_v[k], 1'b0);
  endtask

  task automatic expect_frame(input int k, input string tag, input logic [31:0] exp);
    logic [31:0] f;
    int n;
    check({tag, "_present"}, frames[k].size() > 0, 1'b1);
    if (frames[k].size() > 0) begin
      f = frames[k].pop_front();
      n = bits[k].pop_front();
      check({tag, "_frame"}, f, exp);
      check({tag, "_bits"}, n, 32);
    end
  endtask

  initial begin
    int cyc, pd, pulses;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs4", {sclk_v[0], sdata_v[0], slatch_v[0], busy_v[0], pending_v[0]}, 0);
    check("rst_outs1", {sclk_v[1], sdata_v[1], slatch_v[1], busy_v[1], pending_v[1]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, CLK_DIV=4
    strobe(0, 16'h1234, 4'b0000);
    check("t1_busy_rise", busy_v[0], 1'b1);
    check("t1_sclk_lo", sclk_v[0], 1'b0);
    check("t1_sdata_msb", sdata_v[0], 1'b0);
    check("t1_no_pending", pending_v[0], 1'b0);
    wait_idle(0, "t1", 0, cyc, pd);
    check("t1_latency", cyc, 264);
    expect_frame(0, "t1", 32'h065B4F66);
    check("t1_lat_pulses", lat_pulse[0], 1);
    check("t1_lat_cycles", lat_cyc[0], 4);

    // Blanking and out-of-range digits
    strobe(0, 16'h0859, 4'b1000);
    wait_idle(0, "t2a", 0, cyc, pd);
    expect_frame(0, "t2a", 32'h007F6D6F);
    strobe(0, 16'hFA00, 4'b0000);
    wait_idle(0, "t2b", 0, cyc, pd);
    expect_frame(0, "t2b", 32'h00003F3F);

    // Pending buffer, newest wins, back-to-back without an idle gap
    strobe(0, 16'h1200, 4'b0000);
    repeat (20) @(negedge clk);
    strobe(0, 16'h1201, 4'b0000);
    check("t3_pending_set", pending_v[0], 1'b1);
    repeat (20) @(negedge clk);
    strobe(0, 16'h1202, 4'b0000);
    check("t3_pending_still", pending_v[0], 1'b1);
    wait_idle(0, "t3", 44, cyc, pd);
    check("t3_total", cyc, 528);
    check("t3_pend_drop", pd, 264);
    expect_frame(0, "t3a", 32'h065B3F3F);
    expect_frame(0, "t3b", 32'h065B3F5B);
    check("t3_no_extra", frames[0].size(), 0);

    // Strobe on the final LAT_GAP cycle while pending overrides the buffered frame
    strobe(0, 16'h0000, 4'b0000);
    repeat (10) @(negedge clk);
    strobe(0, 16'h1111, 4'b0000);
    repeat (250) @(negedge clk);
    strobe(0, 16'h2222, 4'b0000);
    check("t4_pending_clr", pending_v[0], 1'b0);
    check("t4_busy_held", busy_v[0], 1'b1);
    wait_idle(0, "t4", 264, cyc, pd);
    check("t4_total", cyc, 528);
    expect_frame(0, "t4a", 32'h3F3F3F3F);
    expect_frame(0, "t4b", 32'h5B5B5B5B);
    check("t4_no_extra", frames[0].size(), 0);

    // Reset during bit 10 aborts cleanly
    pulses = lat_pulse[0];
    strobe(0, 16'h9876, 4'b0000);
    repeat (20) @(negedge clk);
    strobe(0, 16'h5555, 4'b0000);
    repeat (64) @(negedge clk);
    check("t5_pre_sclk", sclk_v[0], 1'b1);
    check("t5_pre_pending", pending_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {sclk_v[0], sdata_v[0], slatch_v[0], busy_v[0], pending_v[0]}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_no_frame", frames[0].size(), 0);
    check("t5_no_latch", lat_pulse[0], pulses);
    check("t5_still_idle", busy_v[0], 1'b0);
    strobe(0, 16'h4567, 4'b0000);
    wait_idle(0, "t5", 0, cyc, pd);
    check("t5_latency", cyc, 264);
    expect_frame(0, "t5", 32'h666D7D07);

    // CLK_DIV=1
    strobe(1, 16'h3690, 4'b0001);
    check("t6_busy_rise", busy_v[1], 1'b1);
    wait_idle(1, "t6", 0, cyc, pd);
    check("t6_latency", cyc, 66);
    expect_frame(1, "t6", 32'h4F7D6F00);
    check("t6_lat_cycles", lat_cyc[1], 1);
    check("t6_stable1", stab[1], 0);
    check("stable4", stab[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
